// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: major opcodes and instruction field positions.
// Used by the fetch queue to spot the HLT instruction.
package mips32_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_HLT     = 6'h3F;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic is_hlt(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/mips32_iq.sv
// Instruction queue: circular FIFO of {instruction, fetch address}.
// Flush empties it; caller guarantees no push when full without a pop.
module mips32_iq #(
  parameter int AW = 10,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_instr,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  output logic [31:0]   head_instr,
  output logic [AW-1:0] head_addr,
  output logic [CW-1:0] count
);

  logic [31:0]   instr_q [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign head_instr = instr_q[head];
  assign head_addr  = addr_q[head];

  always_ff @(posedge clk1) begin
    if (push && !flush) begin
      instr_q[tail] <= push_instr;
      addr_q[tail]  <= push_addr;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 fetch stage: PC sequencing, single-outstanding imem reads,
// HLT freeze, redirect squash, and a decoupling instruction queue.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int AW = 10,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_npc,
  output logic          fetch_stopped,
  output logic          halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] pc;
  logic [AW-1:0] inflight_addr;
  logic          inflight;
  logic [CW-1:0] count;
  logic [31:0]   head_instr;
  logic [AW-1:0] head_addr;
  logic          xfer;
  logic          enq;
  logic          hlt_arriving;
  logic          rd_en;

  assign if_valid     = count != '0;
  assign xfer         = if_valid && if_ready;
  assign enq          = inflight && !redirect_valid;
  assign hlt_arriving = inflight && is_hlt(imem_rdata);

  // An arriving HLT must block the read that would otherwise overlap it
  assign rd_en = rst_n && !fetch_stopped && !redirect_valid &&
                 !hlt_arriving &&
                 ((int'(count) + int'(inflight)) < DEPTH);

  assign imem_rd_en = rd_en;
  assign imem_addr  = pc;
  assign if_instr   = if_valid ? head_instr : '0;
  assign if_npc     = if_valid ? head_addr + AW'(1) : '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      fetch_stopped <= 1'b0;
      halted        <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) inflight_addr <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (rd_en) pc <= pc + AW'(1);
      if (redirect_valid) fetch_stopped <= 1'b0;
      else if (enq && is_hlt(imem_rdata)) fetch_stopped <= 1'b1;
      if (xfer && is_hlt(if_instr)) halted <= 1'b1;
    end
  end

  mips32_iq #(
    .AW(AW),
    .DEPTH(DEPTH)
  ) u_iq (
    .clk1(clk1),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(enq),
    .push_instr(imem_rdata),
    .push_addr(inflight_addr),
    .pop(xfer),
    .head_instr(head_instr),
    .head_addr(head_addr),
    .count(count)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: stream-level reference model plus
// directed scenarios with literal expectations.
module tb_mips32_fetch_queue;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  npc;
    int          cyc;
  } tr_t;

  logic        clk;
  logic        rst_n;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [9:0]  if_npc;
  logic        fetch_stopped;
  logic        halted;

  logic        w_rd_en;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [9:0]  w_npc;
  logic        w_stop;
  logic        w_halt;
  logic        w_redir;
  logic [9:0]  w_rpc;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  tr_t tr_log[$];
  logic [9:0] rd_log[$];

  int         m_occ;
  logic       m_pend;
  logic [9:0] m_pend_addr;
  logic [9:0] m_pc;
  logic [9:0] m_next;
  logic       m_stop;
  logic       m_halt;

  mips32_fetch_queue #(.AW(10), .DEPTH(4), .RESET_PC(10'h000)) dut (
    .clk1(clk), .rst_n(rst_n),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_npc(if_npc),
    .fetch_stopped(fetch_stopped), .halted(halted)
  );

  mips32_fetch_queue #(.AW(10), .DEPTH(4), .RESET_PC(10'h3FE)) u_wrap (
    .clk1(clk), .rst_n(rst_n),
    .imem_rd_en(w_rd_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .if_valid(w_valid), .if_ready(w_ready),
    .if_instr(w_instr), .if_npc(w_npc),
    .fetch_stopped(w_stop), .halted(w_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    if (w_rd_en) w_rdata <= mem[w_addr];
  end

  function automatic bit op_hlt(input logic [31:0] w);
    return w[31:26] == 6'h3F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: delivery order equals fetch order; redirect restarts both
  always @(negedge clk) begin
    logic exp_rd;
    logic xfer;
    logic enq;
    if (!rst_n) begin
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_if_valid", if_valid, 0);
      m_occ = 0; m_pend = 0; m_pend_addr = '0; m_pc = '0;
      m_next = '0; m_stop = 0; m_halt = 0;
    end else begin
      chk("fetch_stopped", fetch_stopped, m_stop);
      chk("halted", halted, m_halt);
      chk("if_valid", if_valid, m_occ != 0);
      exp_rd = !m_stop && !redirect_valid && (m_occ + m_pend < 4) &&
               !(m_pend && op_hlt(mem[m_pend_addr]));
      chk("imem_rd_en", imem_rd_en, exp_rd);
      if (imem_rd_en) begin
        chk("imem_addr", imem_addr, m_pc);
        rd_log.push_back(imem_addr);
      end
      xfer = if_valid && if_ready;
      if (xfer) begin
        chk("if_instr", if_instr, mem[m_next]);
        chk("if_npc", if_npc, m_next + 10'd1);
        tr_log.push_back('{instr: if_instr, npc: if_npc, cyc: cyc});
        if (op_hlt(mem[m_next])) m_halt = 1;
      end
      enq = m_pend && !redirect_valid;
      if (redirect_valid) begin
        m_stop = 0; m_occ = 0; m_pend = 0;
        m_next = redirect_pc; m_pc = redirect_pc;
      end else begin
        if (enq && op_hlt(mem[m_pend_addr])) m_stop = 1;
        m_occ = m_occ + int'(enq) - int'(xfer);
        if (xfer) m_next = m_next + 10'd1;
        m_pend = imem_rd_en;
        if (imem_rd_en) begin
          m_pend_addr = m_pc;
          m_pc = m_pc + 10'd1;
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rd_en", imem_rd_en, 0);
    chk("async_addr", imem_addr, 10'h000);
    chk("async_valid", if_valid, 0);
    chk("async_instr", if_instr, 32'h0);
    chk("async_npc", if_npc, 10'h000);
    chk("async_stopped", fetch_stopped, 0);
    chk("async_halted", halted, 0);
    chk("async_wrap_addr", w_addr, 10'h3FE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tr_log.delete();
    rd_log.delete();
  endtask

  task automatic redirect(input logic [9:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Wrap instance: RESET_PC = 0x3FE, decode always ready
  initial begin
    int n;
    n = 0;
    wait (rst_n === 1'b1);
    @(negedge clk);
    chk("wrap_first_rd", {w_rd_en, w_addr}, {1'b1, 10'h3FE});
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (w_valid) begin
        case (n)
          0: chk("wrap_t0", {w_instr, w_npc}, {32'h200003FE, 10'h3FF});
          1: chk("wrap_t1", {w_instr, w_npc}, {32'h200003FF, 10'h000});
          default: chk("wrap_t2", {w_instr, w_npc}, {32'h2801000a, 10'h001});
        endcase
        n++;
      end
      @(negedge clk);
    end
    chk("wrap_count", n, 3);
  end

  initial begin
    logic [31:0] prog [9];
    int k;
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
             32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
             32'hfc000000};
    for (int i = 0; i < 1024; i++) mem[i] = 32'h20000000 | i;
    for (int i = 0; i < 9; i++) mem[i] = prog[i];
    rst_n = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    w_ready = 1'b1;
    w_redir = 1'b0;
    w_rpc = '0;
    imem_rdata = '0;
    w_rdata = '0;

    // Program to HLT at full throughput
    if_ready = 1'b1;
    reset_dut();
    repeat (20) @(posedge clk);
    #1;
    chk("a_count", tr_log.size(), 9);
    chk("a_reads", rd_log.size(), 9);
    chk("a_halted", halted, 1);
    chk("a_stopped", fetch_stopped, 1);
    if (tr_log.size() == 9) begin
      chk("a_t0", {tr_log[0].instr, tr_log[0].npc}, {32'h2801000a, 10'd1});
      chk("a_t5", tr_log[5].instr, 32'h00222000);
      chk("a_t8", {tr_log[8].instr, tr_log[8].npc}, {32'hfc000000, 10'd9});
      chk("a_rate", tr_log[8].cyc - tr_log[0].cyc, 8);
    end

    // Redirect while halted
    tr_log.delete();
    redirect(10'h010);
    repeat (6) @(posedge clk);
    #1;
    chk("h_halted", halted, 1);
    chk("h_stopped", fetch_stopped, 0);
    if (tr_log.size() > 0) chk("h_t0", tr_log[0].instr, 32'h20000010);
    else chk("h_t0_seen", 0, 1);

    // Decode stalled from reset
    if_ready = 1'b0;
    reset_dut();
    repeat (10) @(posedge clk);
    #1;
    chk("b_reads", rd_log.size(), 4);
    if (rd_log.size() == 4) chk("b_last_addr", rd_log[3], 10'd3);
    chk("b_rd_en", imem_rd_en, 0);
    if_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("b_count", tr_log.size(), 9);
    if (tr_log.size() == 9) chk("b_t4", tr_log[4].npc, 10'd5);

    // Redirect with 3 queued and a read in flight
    if_ready = 1'b0;
    reset_dut();
    repeat (4) @(posedge clk);
    #1;
    redirect(10'h040);
    if_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    if (tr_log.size() >= 2) begin
      chk("c_t0", {tr_log[0].instr, tr_log[0].npc}, {32'h20000040, 10'h041});
      chk("c_t1", tr_log[1].npc, 10'h042);
    end else chk("c_seen", tr_log.size(), 2);
    if (rd_log.size() >= 5) chk("c_rd4", rd_log[4], 10'h040);
    else chk("c_reads", rd_log.size(), 5);

    // Redirect concurrent with transfer of addr 2
    if_ready = 1'b1;
    reset_dut();
    k = 0;
    while (!(if_valid && if_npc == 10'd3) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("d_reach_addr2", k < 20, 1);
    redirect(10'h100);
    repeat (6) @(posedge clk);
    #1;
    if (tr_log.size() >= 4) begin
      chk("d_npc", {tr_log[0].npc, tr_log[1].npc, tr_log[2].npc},
          {10'd1, 10'd2, 10'd3});
      chk("d_t3", {tr_log[3].instr, tr_log[3].npc}, {32'h20000100, 10'h101});
    end else chk("d_seen", tr_log.size(), 4);

    // Reset mid-stream with a read in flight
    if_ready = 1'b1;
    reset_dut();
    repeat (5) @(posedge clk);
    #1;
    chk("e_busy", imem_rd_en, 1);
    reset_dut();
    repeat (15) @(posedge clk);
    #1;
    if (rd_log.size() > 0) chk("e_rd0", rd_log[0], 10'h000);
    else chk("e_reads", rd_log.size(), 1);
    chk("e_count", tr_log.size(), 9);
    if (tr_log.size() > 0) chk("e_t0", tr_log[0].npc, 10'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
